serial_subtractor: RTL

- Bit-serial N-bit unsigned subtractor computing a − b, LSB first, one bit per clock.
- Its per-bit datapath is the half-subtractor cell extended with a registered borrow: a full-subtractor cell whose borrow flip-flop feeds the next bit.
- Trades latency for area, for use where a parallel ripple subtractor is too large.
- Start/done handshake to an upstream controller.

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop
// walks the operands LSB first and publishes a - b after WIDTH clocks.
module serial_subtractor_fs_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bff_q, bff_d, borrow_q, borrow_d;
  logic             d_bit, bout_bit;

  serial_subtractor_fs_cell u_cell (
    .x_i   (sa_q[0]),
    .y_i   (sb_q[0]),
    .bin_i (bff_q),
    .d_o   (d_bit),
    .bout_o(bout_bit)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bff_d    = bff_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    case (state_q)
      IDLE: if (start) begin
        sa_d    = a;
        sb_d    = b;
        bff_d   = 1'b0;
        cnt_d   = '0;
        res_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bff_d = bout_bit;
        cnt_d = cnt_q + CW'(1);
        // Only the completed word is ever published; partial bits stay internal.
        if (cnt_q == CW'(WIDTH-1)) begin
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bout_bit;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bff_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bff_q    <= bff_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
endmodule
